// File: rtl/processor_core_if.sv
// Bus between the single-cycle core and its external instruction/data memories.
// Handshake: none; the core fetches combinationally at pc each cycle, and WR qualifies address/writeData for that cycle only.
interface processor_core_if;
  logic [31:0] instruction;
  logic [31:0] readData;
  logic [7:0]  pc;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        WR;
  logic        MemtoRegOut;

  modport master (
    input  instruction, readData,
    output pc, address, writeData, WR, MemtoRegOut
  );

  modport slave (
    output instruction, readData,
    input  pc, address, writeData, WR, MemtoRegOut
  );
endinterface

// File: rtl/processor_core.sv
// Single-cycle ARM-subset core: conditional data processing, LDR/STR immediate, absolute B<cond>.
// All architectural state (r0-r14, NZCV, pc) commits on the rising clk edge.
module processor_core (
  input  logic             clk,
  input  logic             rst,
  processor_core_if.master bus
);
  logic [31:0] regs_q [0:14];
  logic [3:0]  nzcv_q, nzcv_d;
  logic [7:0]  pc_q, pc_d;

  logic        reg_we;
  logic [3:0]  reg_wa;
  logic [31:0] reg_wd;

  logic [31:0] instr;
  logic [1:0]  op;
  logic [3:0]  opcode, rn, rd, rm;
  logic        cond_ok, test_op, is_arith;
  logic [31:0] rn_val, rd_val, rm_val, op2, dp_res, mem_addr, alu_res;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic [3:0]  flags_new;
  logic        wr, mtr;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  assign instr  = bus.instruction;
  assign op     = instr[27:26];
  assign opcode = instr[24:21];
  assign rn     = instr[19:16];
  assign rd     = instr[15:12];
  assign rm     = instr[3:0];

  // r15 reads as pc+8; it is never a write target.
  assign rn_val = (rn == 4'hF) ? ({24'b0, pc_q} + 32'd8) : regs_q[rn];
  assign rd_val = (rd == 4'hF) ? ({24'b0, pc_q} + 32'd8) : regs_q[rd];
  assign rm_val = (rm == 4'hF) ? ({24'b0, pc_q} + 32'd8) : regs_q[rm];

  always_comb begin
    cond_ok = 1'b0;
    case (instr[31:28])
      4'b0000: cond_ok = nzcv_q[2];
      4'b0001: cond_ok = !nzcv_q[2];
      4'b0010: cond_ok = nzcv_q[1];
      4'b0011: cond_ok = !nzcv_q[1];
      4'b0100: cond_ok = nzcv_q[3];
      4'b0101: cond_ok = !nzcv_q[3];
      4'b0110: cond_ok = nzcv_q[0];
      4'b0111: cond_ok = !nzcv_q[0];
      4'b1000: cond_ok = nzcv_q[1] && !nzcv_q[2];
      4'b1001: cond_ok = !nzcv_q[1] || nzcv_q[2];
      4'b1010: cond_ok = (nzcv_q[3] == nzcv_q[0]);
      4'b1011: cond_ok = (nzcv_q[3] != nzcv_q[0]);
      4'b1100: cond_ok = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
      4'b1101: cond_ok = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Register-specified shifts (bit 4 set) shift by zero.
  always_comb begin
    op2 = rm_val;
    if (instr[25]) begin
      op2 = ror32({24'b0, instr[7:0]}, {instr[11:8], 1'b0});
    end else if (!instr[4]) begin
      case (instr[6:5])
        2'b00:   op2 = rm_val << instr[11:7];
        2'b01:   op2 = rm_val >> instr[11:7];
        2'b10:   op2 = 32'($signed(rm_val) >>> instr[11:7]);
        default: op2 = ror32(rm_val, instr[11:7]);
      endcase
    end
  end

  // Subtraction is a + ~b + 1, so carry-out is ARM's "no borrow".
  always_comb begin
    add_a    = rn_val;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (opcode)
      4'b0010, 4'b0110, 4'b1010: begin add_b = ~op2; add_cin = 1'b1; end
      4'b0011, 4'b0111:          begin add_a = op2; add_b = ~rn_val; add_cin = 1'b1; end
      4'b0100, 4'b0101, 4'b1011: ;
      default:                   is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  always_comb begin
    dp_res = sum[31:0];
    case (opcode)
      4'b0000, 4'b1000: dp_res = rn_val & op2;
      4'b0001, 4'b1001: dp_res = rn_val ^ op2;
      4'b1100:          dp_res = rn_val | op2;
      4'b1101:          dp_res = op2;
      4'b1110:          dp_res = rn_val & ~op2;
      4'b1111:          dp_res = ~op2;
      default:          dp_res = sum[31:0];
    endcase
  end

  assign flags_new = is_arith
    ? {dp_res[31], dp_res == 32'd0, sum[32], (add_a[31] == add_b[31]) && (sum[31] != add_a[31])}
    : {dp_res[31], dp_res == 32'd0, nzcv_q[1:0]};

  assign test_op  = (opcode[3:2] == 2'b10);
  assign mem_addr = instr[23] ? (rn_val + {20'b0, instr[11:0]}) : (rn_val - {20'b0, instr[11:0]});
  assign alu_res  = (op == 2'b01) ? mem_addr : dp_res;

  always_comb begin
    pc_d   = pc_q + 8'd4;
    nzcv_d = nzcv_q;
    reg_we = 1'b0;
    reg_wa = rd;
    reg_wd = dp_res;
    wr     = 1'b0;
    mtr    = 1'b0;
    if (cond_ok) begin
      case (op)
        2'b00: begin
          reg_we = !test_op && (rd != 4'hF);
          if (instr[20] || test_op) nzcv_d = flags_new;
        end
        2'b01: begin
          if (instr[20]) begin
            mtr    = 1'b1;
            reg_wd = bus.readData;
            reg_we = (rd != 4'hF);
          end else begin
            wr = 1'b1;
          end
        end
        2'b10: if (instr[25]) pc_d = instr[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= 8'd0;
      nzcv_q <= 4'd0;
      for (int i = 0; i < 15; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      nzcv_q <= nzcv_d;
      if (reg_we) regs_q[reg_wa] <= reg_wd;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.address     = alu_res;
  assign bus.writeData   = rd_val;
  assign bus.WR          = wr && rst;
  assign bus.MemtoRegOut = mtr && rst;
endmodule

// File: tb/tb_processor_core.sv
// Directed program from the core's reference sequence, then random instructions checked
// against an instruction-level model of the architectural state.
module tb_processor_core;
  logic clk;
  logic rst;
  processor_core_if bus ();

  processor_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] m_regs [0:14];
  logic [3:0]  m_nzcv;
  logic [7:0]  m_pc;

  logic [31:0] last_addr, last_wdata;
  logic [7:0]  last_pc;
  logic        last_wr, last_mtr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 32'd0;
    m_nzcv = 4'd0;
    m_pc   = 8'd0;
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] i);
    if (i == 4'd15) return 32'(m_pc) + 32'd8;
    return m_regs[i];
  endfunction

  function automatic bit cond_holds(input logic [3:0] c);
    bit n, z, cy, v;
    {n, z, cy, v} = m_nzcv;
    case (c)
      0: return z;             1: return !z;
      2: return cy;            3: return !cy;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return cy && !z;      9: return !cy || z;
      10: return n == v;       11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic arith(input logic [31:0] x, input logic [31:0] y, input bit sub,
                       output logic [31:0] r, output bit c, output bit v);
    longint ux, uy, sx, sy, sr;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (sub) begin
      r = x - y; c = (ux >= uy); sr = sx - sy;
    end else begin
      r = x + y; c = (ux + uy) > 64'hFFFF_FFFF; sr = sx + sy;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  // One instruction: predict outputs, compare at the falling edge, then retire into the model.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata);
    logic [31:0] a, rdv, op2, res, e_addr, rm;
    logic [3:0]  opc, rdi;
    logic [1:0]  op;
    bit ex, is_ar, c_n, v_n, e_wr, e_mtr;
    int sh;
    logic [7:0]  n_pc;
    bus.instruction = ins;
    bus.readData    = rdata;
    ex  = cond_holds(ins[31:28]);
    op  = ins[27:26];
    opc = ins[24:21];
    rdi = ins[15:12];
    a   = m_rd(ins[19:16]);
    rdv = m_rd(rdi);
    if (ins[25]) begin
      op2 = rotr(32'(ins[7:0]), 2 * int'(ins[11:8]));
    end else begin
      rm = m_rd(ins[3:0]);
      sh = ins[4] ? 0 : int'(ins[11:7]);
      case (ins[6:5])
        2'd0: op2 = rm << sh;
        2'd1: op2 = rm >> sh;
        2'd2: op2 = 32'($signed(rm) >>> sh);
        default: op2 = rotr(rm, sh);
      endcase
    end
    is_ar = 1'b1; c_n = m_nzcv[1]; v_n = m_nzcv[0];
    case (opc)
      0, 8:      begin res = a & op2;  is_ar = 0; end
      1, 9:      begin res = a ^ op2;  is_ar = 0; end
      2, 6, 10:  arith(a, op2, 1'b1, res, c_n, v_n);
      3, 7:      arith(op2, a, 1'b1, res, c_n, v_n);
      4, 5, 11:  arith(a, op2, 1'b0, res, c_n, v_n);
      12:        begin res = a | op2;  is_ar = 0; end
      13:        begin res = op2;      is_ar = 0; end
      14:        begin res = a & ~op2; is_ar = 0; end
      default:   begin res = ~op2;     is_ar = 0; end
    endcase
    if (!is_ar) begin c_n = m_nzcv[1]; v_n = m_nzcv[0]; end
    e_addr = (op == 2'b01) ? (ins[23] ? a + 32'(ins[11:0]) : a - 32'(ins[11:0])) : res;
    e_wr   = ex && op == 2'b01 && !ins[20];
    e_mtr  = ex && op == 2'b01 && ins[20];
    n_pc   = (ex && op == 2'b10 && ins[25]) ? ins[7:0] : m_pc + 8'd4;

    @(negedge clk);
    last_pc = bus.pc; last_addr = bus.address; last_wdata = bus.writeData;
    last_wr = bus.WR; last_mtr = bus.MemtoRegOut;
    check("pc", 32'(last_pc), 32'(m_pc));
    check("address", last_addr, e_addr);
    check("writeData", last_wdata, rdv);
    check("WR", 32'(last_wr), 32'(e_wr));
    check("MemtoRegOut", 32'(last_mtr), 32'(e_mtr));

    if (ex && op == 2'b00) begin
      if (opc[3:2] != 2'b10 && rdi != 4'd15) m_regs[rdi] = res;
      if (ins[20] || opc[3:2] == 2'b10) m_nzcv = {res[31], res == 32'd0, c_n, v_n};
    end
    if (e_mtr && rdi != 4'd15) m_regs[rdi] = rdata;
    m_pc = n_pc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] c;
    int kind;
    c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    kind = $urandom_range(0, 9);
    if (kind <= 5)
      return {c, 2'b00, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
    if (kind <= 7)
      return {c, 2'b01, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
    if (kind == 8)
      return {c, 3'b101, 1'($urandom), 16'($urandom), 8'($urandom_range(0, 63) * 4)};
    return {c, 2'b11, 26'($urandom)};
  endfunction

  initial begin
    rst = 1'b0;
    bus.instruction = 32'd0;
    bus.readData    = 32'd0;
    model_reset();
    #12;
    check("reset_pc", 32'(bus.pc), 32'd0);
    check("reset_WR", 32'(bus.WR), 32'd0);
    check("reset_writeData", bus.writeData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    step(32'he3a00002, 0); check("mov_r0_addr", last_addr, 32'd2); check("pc0", 32'(last_pc), 32'h00);
    step(32'he2800002, 0); check("add_r0_addr", last_addr, 32'd4); check("pc4", 32'(last_pc), 32'h04);
    step(32'he3a01002, 0); check("pc8", 32'(last_pc), 32'h08);
    step(32'he3a02003, 0);
    step(32'he0813002, 0); check("add_r3_addr", last_addr, 32'd5);
    step(32'he1530000, 0); check("cmp_r3_r0", last_addr, 32'd1);
    step(32'hca00002c, 0);
    step(32'hba00003c, 0); check("bgt_taken", 32'(last_pc), 32'h2c);
    step(32'he1520000, 0); check("blt_not_taken", 32'(last_pc), 32'h30);
    step(32'hca00004c, 0);
    step(32'hba00005c, 0); check("bgt_after_neg", 32'(last_pc), 32'h38);
    step(32'hea00006c, 0); check("blt_after_neg", 32'(last_pc), 32'h5c);
    step(32'he2400002, 0); check("b_always", 32'(last_pc), 32'h6c); check("sub_addr", last_addr, 32'd2);
    step(32'he1e00001, 0); check("mvn_addr", last_addr, 32'hFFFF_FFFD);
    step(32'he0210002, 0); check("eor_addr", last_addr, 32'd1);
    step(32'he3a04080, 0); check("mov_r4_addr", last_addr, 32'h80);
    step(32'h00000000, 0); check("andeq_skip_wr", 32'(last_wr), 32'd0);
    step(32'he5821004, 0);
    check("str_WR", 32'(last_wr), 32'd1); check("str_addr", last_addr, 32'd7); check("str_wdata", last_wdata, 32'd2);
    step(32'he5925000, 32'hA5); check("ldr_mtr", 32'(last_mtr), 32'd1);
    step(32'he2856000, 0); check("ldr_result_r5", last_addr, 32'hA5);
    step(32'hea0000fc, 0);
    step(32'he1a00000, 0); check("pc_fc", 32'(last_pc), 32'hFC);
    step(32'he1a00000, 0); check("pc_wrap", 32'(last_pc), 32'h00);

    for (int i = 0; i < 400; i++) step(rand_instr(), $urandom);

    // Reset in the middle of a store cycle.
    step(32'he3a01009, 0);
    bus.instruction = 32'he5821004;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_pc", 32'(bus.pc), 32'd0);
    check("midrst_WR", 32'(bus.WR), 32'd0);
    check("midrst_r1", bus.writeData, 32'd0);
    check("midrst_addr", bus.address, 32'd4);
    @(posedge clk); #1;
    rst = 1'b1;
    step(32'he0817002, 0); check("post_rst_add", last_addr, 32'd0);
    step(32'h00000000, 0); check("post_rst_pc", 32'(last_pc), 32'd4);
    for (int i = 0; i < 100; i++) step(rand_instr(), $urandom);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
